io_port_bank: RTL and testbench

Parametrised I/O port bank for the single-cycle CPU. It replaces the four fixed output registers and the 4:1 input multiplexer with NPORTS output ports and NPORTS input ports of WIDTH bits each. Input ports get a multi-stage synchroniser and sticky change flags. Output ports get a per-port write strobe. It sits between the datapath (regfile or immediate write data, input data towards the regfile write mux) and the board pins.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_sync.sv | 33 +++
 rtl/io_port_bank.sv | 147 ++++++++++++++
 tb/tb_io_port_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the parametrised I/O port bank: default geometry,
// warm-up FSM states and the port slicing helper.
package io_pkg;

    localparam int IO_WIDTH       = 8;
    localparam int IO_NPORTS      = 4;
    localparam int IO_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } io_state_e;

    // Low bit of port k inside a packed NPORTS*WIDTH bus.
    function automatic int port_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/io_sync.sv
// WIDTH-wide, STAGES-deep flop chain that brings an asynchronous pin group
// into the clk domain; every stage clears to zero on reset.
module io_sync
    import io_pkg::*;
#(
    parameter int WIDTH  = IO_WIDTH,
    parameter int STAGES = IO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the pin value one stage further down the chain every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// NPORTS registered output ports with write strobes, and NPORTS synchronised
// input ports with sticky change flags gated by a post-reset warm-up FSM.
module io_port_bank
    import io_pkg::*;
#(
    parameter int  WIDTH       = IO_WIDTH,
    parameter int  NPORTS      = IO_NPORTS,
    parameter int  SYNC_STAGES = IO_SYNC_STAGES,
    localparam int SELW        = $clog2(NPORTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [SELW-1:0]         wsel,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    re,
    input  logic [SELW-1:0]         rsel,
    output logic [WIDTH-1:0]        rdata,
    input  logic [NPORTS*WIDTH-1:0] ext_in,
    output logic [NPORTS*WIDTH-1:0] ext_out,
    output logic [NPORTS-1:0]       out_stb,
    output logic [NPORTS-1:0]       chg,
    output logic                    irq
);

    localparam int CNTW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]        sync_s [NPORTS];
    logic [WIDTH-1:0]        prev_r [NPORTS];
    logic [NPORTS*WIDTH-1:0] ext_out_r;
    logic [NPORTS-1:0]       out_stb_r;
    logic [NPORTS-1:0]       chg_r;
    logic [NPORTS-1:0]       chg_n;
    logic [WIDTH-1:0]        rdata_s;
    io_state_e               state_r;
    io_state_e               state_n;
    logic [CNTW-1:0]         cnt_r;
    logic [CNTW-1:0]         cnt_n;

    for (genvar k = 0; k < NPORTS; k++) begin : g_sync
        io_sync #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (ext_in[port_lo(k, WIDTH) +: WIDTH]),
            .q     (sync_s[k])
        );
    end

    // Output ports: load on a matching write, strobe only on the written cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_out_r <= '0;
            out_stb_r <= '0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (we && (wsel == SELW'(k))) begin
                    ext_out_r[port_lo(k, WIDTH) +: WIDTH] <= wdata;
                    out_stb_r[k] <= 1'b1;
                end else begin
                    out_stb_r[k] <= 1'b0;
                end
            end
        end
    end

    // Warm-up state and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WARM;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Stay in WARM until the synchroniser chain has flushed its reset zeros.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            WARM: begin
                if (cnt_r == CNTW'(SYNC_STAGES)) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt_r + CNTW'(1);
                end
            end
            RUN: begin
                state_n = RUN;
            end
            default: begin
                state_n = WARM;
                cnt_n   = '0;
            end
        endcase
    end

    // Change flags: a detected change outranks a same-edge read clear.
    always_comb begin
        chg_n = chg_r;
        for (int k = 0; k < NPORTS; k++) begin
            if ((state_r == RUN) && (sync_s[k] != prev_r[k])) begin
                chg_n[k] = 1'b1;
            end else if (re && (rsel == SELW'(k))) begin
                chg_n[k] = 1'b0;
            end else begin
                chg_n[k] = chg_r[k];
            end
        end
    end

    // Previous synchronised value and sticky change flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NPORTS; k++) begin
                prev_r[k] <= '0;
            end
            chg_r <= '0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                prev_r[k] <= sync_s[k];
            end
            chg_r <= chg_n;
        end
    end

    // Read mux; an out-of-range select reads as zero.
    always_comb begin
        rdata_s = '0;
        if (int'(rsel) < NPORTS) begin
            rdata_s = sync_s[rsel];
        end else begin
            rdata_s = '0;
        end
    end

    assign rdata   = rdata_s;
    assign ext_out = ext_out_r;
    assign out_stb = out_stb_r;
    assign chg     = chg_r;
    assign irq     = |chg_r;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios with literal
// expectations plus randomized traffic checked against a delay-line model.
module tb_io_port_bank;

    localparam int W  = 8;
    localparam int NP = 4;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic [1:0]    wsel = 2'd0;
    logic [W-1:0]  wdata = 8'd0;
    logic          re = 1'b0;
    logic [1:0]    rsel = 2'd0;
    logic [W-1:0]  rdata;
    logic [NP*W-1:0] ext_in = '0;
    logic [NP*W-1:0] ext_out;
    logic [NP-1:0] out_stb;
    logic [NP-1:0] chg;
    logic          irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    io_port_bank #(.WIDTH(W), .NPORTS(NP), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wsel    (wsel),
        .wdata   (wdata),
        .re      (re),
        .rsel    (rsel),
        .rdata   (rdata),
        .ext_in  (ext_in),
        .ext_out (ext_out),
        .out_stb (out_stb),
        .chg     (chg),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples per edge; sync is the sample S-1 edges old,
    // prev the one S edges old; change flags enabled from edge S+2 after reset.
    logic [NP*W-1:0] samp_m [0:S];
    logic [NP*W-1:0] out_m = '0;
    logic [NP-1:0]   stb_m = '0;
    logic [NP-1:0]   chg_m = '0;
    int              edges_m = 0;
    bit              model_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [NP*W-1:0] samp_n [0:S];
        logic [NP*W-1:0] out_n;
        logic [NP-1:0]   stb_n;
        logic [NP-1:0]   chg_n;
        if (reset) begin
            for (int i = 0; i <= S; i++) samp_m[i] <= '0;
            out_m <= '0;
            stb_m <= '0;
            chg_m <= '0;
            edges_m <= 0;
            model_valid <= 1'b1;
        end else begin
            chg_n = chg_m;
            for (int k = 0; k < NP; k++) begin
                if ((edges_m + 1 >= S + 2) && (samp_m[S-1][k*W +: W] != samp_m[S][k*W +: W]))
                    chg_n[k] = 1'b1;
                else if (re && int'(rsel) == k)
                    chg_n[k] = 1'b0;
            end
            out_n = out_m;
            stb_n = '0;
            if (we && int'(wsel) < NP) begin
                out_n[int'(wsel)*W +: W] = wdata;
                stb_n[wsel] = 1'b1;
            end
            for (int i = S; i >= 1; i--) samp_n[i] = samp_m[i-1];
            samp_n[0] = ext_in;
            samp_m <= samp_n;
            out_m <= out_n;
            stb_m <= stb_n;
            chg_m <= chg_n;
            edges_m <= edges_m + 1;
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ext_out", 64'(ext_out), 64'(out_m));
            check("out_stb", 64'(out_stb), 64'(stb_m));
            check("chg", 64'(chg), 64'(chg_m));
            check("irq", 64'(irq), 64'(|chg_m));
            check("rdata", 64'(rdata), 64'(samp_m[S-1][int'(rsel)*W +: W]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_ext_out", 64'(ext_out), 64'h0);
        check("rst_out_stb", 64'(out_stb), 64'h0);
        check("rst_chg", 64'(chg), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        reset = 1'b0;

        // Single write to port 2
        we = 1'b1; wsel = 2'd2; wdata = 8'hA5;
        tick();
        check("wr_port2", 64'(ext_out), 64'h00A5_0000);
        check("wr_stb", 64'(out_stb), 64'b0100);
        we = 1'b0;
        tick();
        check("wr_stb_drop", 64'(out_stb), 64'b0000);
        check("wr_hold", 64'(ext_out), 64'h00A5_0000);

        // Back-to-back writes to port 1
        we = 1'b1; wsel = 2'd1; wdata = 8'h11;
        tick();
        check("b2b_11", 64'(ext_out), 64'h00A5_1100);
        check("b2b_stb1", 64'(out_stb), 64'b0010);
        wdata = 8'h22;
        tick();
        check("b2b_22", 64'(ext_out), 64'h00A5_2200);
        check("b2b_stb2", 64'(out_stb), 64'b0010);
        wdata = 8'h33;
        tick();
        check("b2b_33", 64'(ext_out), 64'h00A5_3300);
        check("b2b_stb3", 64'(out_stb), 64'b0010);
        we = 1'b0;
        tick();
        check("b2b_stb_end", 64'(out_stb), 64'b0000);

        // Input change on port 3
        rsel = 2'd3;
        ext_in[3*W +: W] = 8'h3C;
        tick();
        check("in_rdata_e1", 64'(rdata), 64'h00);
        tick();
        check("in_rdata_e2", 64'(rdata), 64'h3C);
        check("in_chg_e2", 64'(chg), 64'b0000);
        tick();
        check("in_chg_e3", 64'(chg), 64'b1000);
        check("in_irq_e3", 64'(irq), 64'h1);
        re = 1'b1;
        tick();
        check("in_clr", 64'(chg), 64'b0000);
        check("in_clr_irq", 64'(irq), 64'h0);
        re = 1'b0;

        // Set wins over same-edge read clear
        rsel = 2'd0;
        ext_in[0 +: W] = 8'h55;
        tick();
        tick();
        re = 1'b1;
        tick();
        check("coll_set_wins", 64'(chg), 64'b0001);
        tick();
        check("coll_clear_after", 64'(chg), 64'b0000);
        re = 1'b0;

        // Non-zero pins held through reset release raise no change
        ext_in[0 +: W] = 8'hFF;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("warm_chg", 64'(chg), 64'h0);
        end
        check("warm_rdata", 64'(rdata), 64'hFF);

        // Reset in the middle of activity
        we = 1'b1; wsel = 2'd1; wdata = 8'h7E;
        ext_in[1*W +: W] = 8'h01;
        ext_in[2*W +: W] = 8'h02;
        tick();
        we = 1'b0;
        tick();
        tick();
        check("mid_chg_pre", 64'(chg), 64'b0110);
        check("mid_port1_pre", 64'(ext_out[1*W +: W]), 64'h7E);
        reset = 1'b1; we = 1'b1; wsel = 2'd0; wdata = 8'hFF; re = 1'b1; rsel = 2'd1;
        tick();
        check("mid_ext_out", 64'(ext_out), 64'h0);
        check("mid_out_stb", 64'(out_stb), 64'h0);
        check("mid_chg", 64'(chg), 64'h0);
        check("mid_irq", 64'(irq), 64'h0);
        check("mid_rdata", 64'(rdata), 64'h0);
        reset = 1'b0; we = 1'b0; re = 1'b0;
        ext_in[3*W +: W] = 8'h99;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("mid_warm_chg", 64'(chg), 64'h0);
        end

        // Randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            we    = 1'($urandom_range(0, 1));
            wsel  = 2'($urandom_range(0, 3));
            wdata = 8'($urandom);
            re    = ($urandom_range(0, 3) == 0);
            rsel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                ext_in[$urandom_range(0, 3)*W +: W] = 8'($urandom);
            tick();
        end
        reset = 1'b0; we = 1'b0; re = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
